// File: rtl/input_tile_loader.sv
// -----------------------------------------------------------------------------
// input_tile_loader
//
// Purpose:
//   Collects a stream of elements into QUEUE_NUM x QUEUE_LEN tiles, filled
//   row-major. Two banks alternate (ping-pong), so one bank fills while the
//   other is presented downstream. A tile closes after its last position is
//   written, or earlier when i_in_last is seen. An early-closed tile carries
//   zeros in its unwritten positions and raises o_post_padded.
//
// Ports:
//   i_clk          clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_in_valid     upstream element valid
//   o_in_ready     loader can accept an element (filling bank not FULL)
//   i_in_data      streamed element
//   i_in_last      final element of the current tile (qualified by valid)
//   o_post_valid   a complete tile is presented
//   i_post_ready   downstream accepts the presented tile
//   o_post_data    presented tile, indexed [row][col]
//   o_post_padded  presented tile was closed early and zero-padded
//   o_busy         at least one bank is FILLING or FULL
// -----------------------------------------------------------------------------
module input_tile_loader #(
    parameter int unsigned QUEUE_NUM = 3,
    parameter int unsigned QUEUE_LEN = 9,
    parameter int unsigned IN_WIDTH  = 8
) (
    input  logic                                            i_clk,
    input  logic                                            i_rst_n,
    input  logic                                            i_in_valid,
    output logic                                            o_in_ready,
    input  logic [IN_WIDTH-1:0]                             i_in_data,
    input  logic                                            i_in_last,
    output logic                                            o_post_valid,
    input  logic                                            i_post_ready,
    output logic [QUEUE_NUM-1:0][QUEUE_LEN-1:0][IN_WIDTH-1:0] o_post_data,
    output logic                                            o_post_padded,
    output logic                                            o_busy
);

    localparam int unsigned ROW_W = (QUEUE_NUM > 1) ? $clog2(QUEUE_NUM) : 1;
    localparam int unsigned COL_W = (QUEUE_LEN > 1) ? $clog2(QUEUE_LEN) : 1;
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(QUEUE_NUM - 1);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(QUEUE_LEN - 1);

    localparam logic [1:0] ST_EMPTY   = 2'd0;
    localparam logic [1:0] ST_FILLING = 2'd1;
    localparam logic [1:0] ST_FULL    = 2'd2;

    typedef logic [QUEUE_NUM-1:0][QUEUE_LEN-1:0][IN_WIDTH-1:0] tile_t;

    tile_t      [1:0] r_data;
    logic [1:0] [1:0] r_state;
    logic       [1:0] r_padded;
    logic             r_wr_sel;
    logic             r_rd_sel;
    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] r_col;

    logic w_in_fire;
    logic w_post_fire;
    logic w_at_last_idx;
    logic w_close;
    logic w_early;

    assign o_in_ready    = (r_state[r_wr_sel] != ST_FULL);
    assign o_post_valid  = (r_state[r_rd_sel] == ST_FULL);
    assign o_post_data   = r_data[r_rd_sel];
    assign o_post_padded = r_padded[r_rd_sel];
    assign o_busy        = (r_state[0] != ST_EMPTY) | (r_state[1] != ST_EMPTY);

    assign w_in_fire     = i_in_valid & o_in_ready;
    assign w_post_fire   = o_post_valid & i_post_ready;
    assign w_at_last_idx = (r_row == ROW_MAX) && (r_col == COL_MAX);
    assign w_close       = w_in_fire & (w_at_last_idx | i_in_last);
    assign w_early       = w_in_fire & i_in_last & ~w_at_last_idx;

    // A bank is zeroed on release, so positions skipped by an early close
    // already read 0 without any extra padding pass. Release (bank FULL) and
    // write (bank not FULL) can never target the same bank in one cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data   <= '0;
            r_state  <= '0;
            r_padded <= '0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (w_post_fire && (r_rd_sel == 1'(b))) begin
                    r_state[b]  <= ST_EMPTY;
                    r_data[b]   <= '0;
                    r_padded[b] <= 1'b0;
                end else if (w_in_fire && (r_wr_sel == 1'(b))) begin
                    r_data[b][r_row][r_col] <= i_in_data;
                    if (w_close) begin
                        r_state[b]  <= ST_FULL;
                        r_padded[b] <= w_early;
                    end else begin
                        r_state[b]  <= ST_FILLING;
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_sel <= 1'b0;
            r_rd_sel <= 1'b0;
        end else begin
            if (w_close) begin
                r_wr_sel <= ~r_wr_sel;
            end
            if (w_post_fire) begin
                r_rd_sel <= ~r_rd_sel;
            end
        end
    end

    // Row-major position counters; column wraps into row.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_row <= '0;
            r_col <= '0;
        end else if (w_close) begin
            r_row <= '0;
            r_col <= '0;
        end else if (w_in_fire) begin
            if (r_col == COL_MAX) begin
                r_col <= '0;
                r_row <= r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_input_tile_loader.sv
// -----------------------------------------------------------------------------
// tb_input_tile_loader
//
// Directed bench for input_tile_loader with default parameters (3 x 9 x 8).
// Inputs change on the falling edge or 1 ns after the rising edge; outputs are
// observed 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_input_tile_loader;

    localparam int QN = 3;
    localparam int QL = 9;
    localparam int W  = 8;

    typedef logic [QN-1:0][QL-1:0][W-1:0] tile_t;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_in_valid;
    logic        o_in_ready;
    logic [W-1:0] i_in_data;
    logic        i_in_last;
    logic        o_post_valid;
    logic        i_post_ready;
    tile_t       o_post_data;
    logic        o_post_padded;
    logic        o_busy;

    int errors = 0;
    int checks = 0;
    int stalls = 0;
    tile_t delivered [$];

    input_tile_loader #(
        .QUEUE_NUM (QN),
        .QUEUE_LEN (QL),
        .IN_WIDTH  (W)
    ) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_in_valid    (i_in_valid),
        .o_in_ready    (o_in_ready),
        .i_in_data     (i_in_data),
        .i_in_last     (i_in_last),
        .o_post_valid  (o_post_valid),
        .i_post_ready  (i_post_ready),
        .o_post_data   (o_post_data),
        .o_post_padded (o_post_padded),
        .o_busy        (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Record every tile that will be taken at the next rising edge.
    always @(negedge i_clk) begin
        #2;
        if (o_post_valid === 1'b1 && i_post_ready === 1'b1) begin
            delivered.push_back(o_post_data);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Expected tile: first count positions hold base, base+1, ... row-major.
    function automatic tile_t seq_tile(input int base, input int count);
        tile_t t;
        t = '0;
        for (int k = 0; k < count; k++) begin
            t[k / QL][k % QL] = W'(base + k);
        end
        return t;
    endfunction

    // Offer one element and return 1 ns after the edge that accepts it.
    task automatic send(input logic [W-1:0] d, input logic last);
        int n;
        n = 0;
        @(negedge i_clk);
        i_in_valid = 1'b1;
        i_in_data  = d;
        i_in_last  = last;
        while (o_in_ready !== 1'b1 && n < 200) begin
            @(negedge i_clk);
            n++;
            stalls++;
        end
        checks++;
        if (o_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_timeout: data=%0d ready=%b required 1", d, o_in_ready);
            i_in_valid = 1'b0;
            i_in_last  = 1'b0;
        end else begin
            @(posedge i_clk);
            #1;
            i_in_valid = 1'b0;
            i_in_last  = 1'b0;
        end
    endtask

    task automatic release_tile();
        @(negedge i_clk);
        i_post_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_post_ready = 1'b0;
    endtask

    task automatic test_reset();
        i_rst_n      = 1'b0;
        i_in_valid   = 1'b0;
        i_in_data    = '0;
        i_in_last    = 1'b0;
        i_post_ready = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        checks++;
        if (o_in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b required 1", o_in_ready);
        end
        checks++;
        if (o_post_valid !== 1'b0) begin
            errors++; $display("FAIL reset_post_valid: got %b required 0", o_post_valid);
        end
        checks++;
        if (o_post_data !== tile_t'(0)) begin
            errors++; $display("FAIL reset_post_data: got %h required 0", o_post_data);
        end
        checks++;
        if (o_post_padded !== 1'b0) begin
            errors++; $display("FAIL reset_padded: got %b required 0", o_post_padded);
        end
        checks++;
        if (o_busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b required 0", o_busy);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    task automatic test_full_tile();
        tile_t exp;
        exp = seq_tile(1, 27);
        i_post_ready = 1'b1;
        for (int k = 1; k <= 26; k++) send(W'(k), 1'b0);
        checks++;
        if (o_post_valid !== 1'b0) begin
            errors++; $display("FAIL full_early_valid: got %b required 0", o_post_valid);
        end
        checks++;
        if (o_busy !== 1'b1) begin
            errors++; $display("FAIL full_busy: got %b required 1", o_busy);
        end
        send(W'(27), 1'b0);
        checks++;
        if (o_post_valid !== 1'b1) begin
            errors++; $display("FAIL full_valid: got %b required 1", o_post_valid);
        end
        checks++;
        if (o_post_data !== exp) begin
            errors++; $display("FAIL full_data: got %h required %h", o_post_data, exp);
        end
        checks++;
        if (o_post_data[0][0] !== 8'd1 || o_post_data[2][8] !== 8'd27) begin
            errors++;
            $display("FAIL full_corners: got [0][0]=%0d [2][8]=%0d required 1 and 27",
                     o_post_data[0][0], o_post_data[2][8]);
        end
        checks++;
        if (o_post_padded !== 1'b0) begin
            errors++; $display("FAIL full_padded: got %b required 0", o_post_padded);
        end
        @(posedge i_clk);
        #1;
        i_post_ready = 1'b0;
        checks++;
        if (o_post_valid !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL full_release: got valid=%b busy=%b required 0 0", o_post_valid, o_busy);
        end
    endtask

    task automatic test_padded();
        tile_t exp;
        exp = seq_tile(1, 10);
        for (int k = 1; k <= 10; k++) send(W'(k), (k == 10));
        checks++;
        if (o_post_valid !== 1'b1) begin
            errors++; $display("FAIL pad_valid: got %b required 1", o_post_valid);
        end
        checks++;
        if (o_post_data !== exp) begin
            errors++; $display("FAIL pad_data: got %h required %h", o_post_data, exp);
        end
        checks++;
        if (o_post_padded !== 1'b1) begin
            errors++; $display("FAIL pad_flag: got %b required 1", o_post_padded);
        end
        repeat (3) @(posedge i_clk);
        #1;
        checks++;
        if (o_post_valid !== 1'b1 || o_post_data !== exp || o_post_padded !== 1'b1) begin
            errors++;
            $display("FAIL pad_hold: got valid=%b pad=%b data=%h required 1 1 %h",
                     o_post_valid, o_post_padded, o_post_data, exp);
        end
        release_tile();
        checks++;
        if (o_post_valid !== 1'b0 || o_post_padded !== 1'b0) begin
            errors++;
            $display("FAIL pad_release: got valid=%b pad=%b required 0 0",
                     o_post_valid, o_post_padded);
        end
    endtask

    task automatic test_stall();
        tile_t t1, t2, t3;
        t1 = seq_tile(1, 27);
        t2 = seq_tile(28, 27);
        t3 = seq_tile(55, 6);
        delivered.delete();
        i_post_ready = 1'b0;
        for (int k = 1; k <= 54; k++) send(W'(k), 1'b0);
        checks++;
        if (o_in_ready !== 1'b0) begin
            errors++; $display("FAIL stall_ready: got %b required 0", o_in_ready);
        end
        @(negedge i_clk);
        i_in_valid = 1'b1;
        i_in_data  = W'(55);
        repeat (3) @(negedge i_clk);
        checks++;
        if (o_in_ready !== 1'b0 || o_post_data !== t1) begin
            errors++;
            $display("FAIL stall_hold: got ready=%b data=%h required 0 %h",
                     o_in_ready, o_post_data, t1);
        end
        i_post_ready = 1'b1;
        @(posedge i_clk);
        #1;
        checks++;
        if (o_post_valid !== 1'b1 || o_post_data !== t2) begin
            errors++;
            $display("FAIL stall_second: got valid=%b data=%h required 1 %h",
                     o_post_valid, o_post_data, t2);
        end
        checks++;
        if (o_in_ready !== 1'b1) begin
            errors++; $display("FAIL stall_reopen: got %b required 1", o_in_ready);
        end
        @(posedge i_clk);
        #1;
        i_in_valid   = 1'b0;
        i_post_ready = 1'b0;
        checks++;
        if (o_post_valid !== 1'b0) begin
            errors++; $display("FAIL stall_drained: got %b required 0", o_post_valid);
        end
        for (int k = 56; k <= 60; k++) send(W'(k), (k == 60));
        checks++;
        if (o_post_valid !== 1'b1 || o_post_data !== t3 || o_post_padded !== 1'b1) begin
            errors++;
            $display("FAIL stall_tail: got valid=%b pad=%b data=%h required 1 1 %h",
                     o_post_valid, o_post_padded, o_post_data, t3);
        end
        release_tile();
        checks++;
        if (delivered.size() !== 3) begin
            errors++; $display("FAIL stall_count: got %0d tiles required 3", delivered.size());
        end else begin
            checks++;
            if (delivered[0] !== t1 || delivered[1] !== t2 || delivered[2] !== t3) begin
                errors++;
                $display("FAIL stall_order: got %h / %h / %h", delivered[0], delivered[1],
                         delivered[2]);
            end
        end
    endtask

    task automatic test_back_to_back();
        tile_t t1, t2;
        t1 = seq_tile(100, 27);
        t2 = seq_tile(200, 27);
        delivered.delete();
        stalls = 0;
        i_post_ready = 1'b0;
        for (int k = 0; k < 27; k++) send(W'(100 + k), 1'b0);
        for (int k = 0; k < 26; k++) send(W'(200 + k), 1'b0);
        // Tile 1 is taken on the same edge that closes tile 2.
        i_post_ready = 1'b1;
        send(W'(226), 1'b0);
        checks++;
        if (o_post_valid !== 1'b1 || o_post_data !== t2 || o_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second: got valid=%b ready=%b data=%h required 1 1 %h",
                     o_post_valid, o_in_ready, o_post_data, t2);
        end
        @(posedge i_clk);
        #1;
        i_post_ready = 1'b0;
        checks++;
        if (o_busy !== 1'b0) begin
            errors++; $display("FAIL b2b_idle: got busy=%b required 0", o_busy);
        end
        checks++;
        if (stalls !== 0) begin
            errors++; $display("FAIL b2b_stalls: got %0d stall cycles required 0", stalls);
        end
        checks++;
        if (delivered.size() !== 2) begin
            errors++; $display("FAIL b2b_count: got %0d tiles required 2", delivered.size());
        end else begin
            checks++;
            if (delivered[0] !== t1 || delivered[1] !== t2) begin
                errors++;
                $display("FAIL b2b_data: got %h / %h required %h / %h",
                         delivered[0], delivered[1], t1, t2);
            end
        end
    endtask

    task automatic test_reset_mid();
        tile_t exp;
        exp = seq_tile(50, 27);
        i_post_ready = 1'b0;
        for (int k = 1; k <= 13; k++) send(W'(k), 1'b0);
        @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        checks++;
        if (o_busy !== 1'b0 || o_in_ready !== 1'b1 || o_post_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_state: got busy=%b ready=%b valid=%b required 0 1 0",
                     o_busy, o_in_ready, o_post_valid);
        end
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        for (int k = 0; k < 26; k++) send(W'(50 + k), 1'b0);
        checks++;
        if (o_post_valid !== 1'b0) begin
            errors++; $display("FAIL rstmid_early: got valid=%b required 0", o_post_valid);
        end
        send(W'(76), 1'b0);
        checks++;
        if (o_post_valid !== 1'b1 || o_post_data !== exp || o_post_padded !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_tile: got valid=%b pad=%b data=%h required 1 0 %h",
                     o_post_valid, o_post_padded, o_post_data, exp);
        end
        release_tile();
        checks++;
        if (o_busy !== 1'b0) begin
            errors++; $display("FAIL rstmid_idle: got busy=%b required 0", o_busy);
        end
    endtask

    task automatic test_last_final();
        tile_t exp;
        exp = seq_tile(30, 27);
        i_post_ready = 1'b0;
        for (int k = 0; k < 27; k++) send(W'(30 + k), (k == 26));
        checks++;
        if (o_post_valid !== 1'b1 || o_post_data !== exp) begin
            errors++;
            $display("FAIL lastfinal_tile: got valid=%b data=%h required 1 %h",
                     o_post_valid, o_post_data, exp);
        end
        checks++;
        if (o_post_padded !== 1'b0) begin
            errors++; $display("FAIL lastfinal_padded: got %b required 0", o_post_padded);
        end
        release_tile();
    endtask

    initial begin
        test_reset();
        test_full_tile();
        test_padded();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_last_final();
        repeat (2) @(posedge i_clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/input_tile_loader.md
INPUT_TILE_LOADER -- requirements
Module: input_tile_loader

Interface
REQ-001 Parameter QUEUE_NUM, default 3, number of tile rows.
REQ-002 Parameter QUEUE_LEN, default 9, elements per tile row.
REQ-003 Parameter IN_WIDTH, default 8, element width in bits.
REQ-004 i_clk  input  1  sole clock, rising-edge.
REQ-005 i_rst_n  input  1  asynchronous active-low reset.
REQ-006 i_in_valid  input  1  upstream element valid.
REQ-007 o_in_ready  output  1  loader can accept an element.
REQ-008 i_in_data  input  IN_WIDTH  streamed element.
REQ-009 i_in_last  input  1  final element of the current tile, qualified by i_in_valid.
REQ-010 o_post_valid  output  1  a complete tile is presented downstream.
REQ-011 i_post_ready  input  1  downstream accepts the tile.
REQ-012 o_post_data  output  IN_WIDTH x [QUEUE_NUM][QUEUE_LEN]  presented tile.
REQ-013 o_post_padded  output  1  presented tile was closed early and zero-padded; valid with o_post_valid.
REQ-014 o_busy  output  1  at least one bank is non-empty.

Function
REQ-015 in_fire = i_in_valid & o_in_ready; post_fire = o_post_valid & i_post_ready.
REQ-016 The block SHALL hold two tile banks (ping-pong), each in state EMPTY, FILLING, or FULL.
REQ-017 Bank transitions SHALL be: EMPTY->FILLING on first in_fire; FILLING->FULL on closing element; FULL->EMPTY on post_fire.
REQ-018 wr_sel SHALL select the filling bank; rd_sel SHALL select the presenting bank; each toggles on its own bank's close/release.
REQ-019 o_in_ready SHALL be 1 iff bank[wr_sel] is not FULL.
REQ-020 o_post_valid SHALL be 1 iff bank[rd_sel] is FULL; o_post_data and o_post_padded SHALL come from bank[rd_sel] and stay stable while o_post_valid=1 and i_post_ready=0.
REQ-021 Fill order SHALL be row-major: element index k (0..QUEUE_NUM*QUEUE_LEN-1) writes row k/QUEUE_LEN, column k%QUEUE_LEN; tracked by row counter (0..QUEUE_NUM-1) and column counter (0..QUEUE_LEN-1) wrapping column into row.
REQ-022 A bank SHALL close when in_fire occurs at k = QUEUE_NUM*QUEUE_LEN-1 or with i_in_last=1, whichever comes first.
REQ-023 On early close (i_in_last at k < last index), all unwritten positions SHALL read 0 and the bank's padded flag SHALL be 1; otherwise padded=0.
REQ-024 i_in_last at exactly the final index SHALL close normally with padded=0.
REQ-025 On close, counters SHALL return to 0 in the same edge.
REQ-026 Latency: the edge accepting the closing element SHALL set o_post_valid=1 in the following cycle if rd_sel points to that bank.
REQ-027 Simultaneous close of one bank and post_fire of the other SHALL both take effect in the same edge with no lost or duplicated tile.
REQ-028 With both banks FULL, o_in_ready=0 and upstream SHALL stall without data loss until post_fire.
REQ-029 Tiles SHALL be delivered in acceptance order; throughput one element per cycle sustained while downstream accepts one tile per QUEUE_NUM*QUEUE_LEN cycles.
REQ-030 o_busy SHALL be 1 iff either bank is FILLING or FULL.

Reset
REQ-031 While i_rst_n=0: both banks EMPTY, data and padded flags 0, counters 0, wr_sel=rd_sel=0.
REQ-032 Reset outputs: o_in_ready=1, o_post_valid=0, o_post_data all 0, o_post_padded=0, o_busy=0.
REQ-033 Reset asserted mid-fill or mid-present SHALL discard all partial and full tiles; first post-reset element SHALL land at row 0, column 0.

Verification
REQ-034 Defaults, stream 27 elements 1..27 continuously, i_post_ready=1 -> o_post_valid one cycle after 27th accept; o_post_data[0][0]=1, [2][8]=27, padded=0.
REQ-035 Stream 10 elements, i_in_last on 10th -> tile with [0][0..8]=1..9, [1][0]=10, rest 0, o_post_padded=1.
REQ-036 i_post_ready=0, stream 60 elements -> o_in_ready drops after element 54; data held stable; raising i_post_ready releases tiles 1 then 2 in order, then elements 55..60 accepted.
REQ-037 Back-to-back tiles with i_post_ready=1 -> o_in_ready never drops; close and post_fire on same edge handled; two tiles delivered intact.
REQ-038 Assert i_rst_n=0 after 13 elements of a tile, release, stream 27 -> only the new tile appears, starting [0][0]=new first element, o_busy 0 during reset.
REQ-039 i_in_last on element 27 -> normal tile, o_post_padded=0.
